// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between pipeline datapath and hazard_ctrl.
// master drives ID/EX/mem status; slave returns enables and status.
interface hazard_ctrl_if;
   logic [5:0]  id_op;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rt;
   logic [5:0]  ex_op;
   logic [4:0]  ex_rd;
   logic        ex_wen;
   logic        ex_taken;
   logic        dmem_busy;
   logic        pc_we;
   logic        ifid_we;
   logic        pipe_en;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        err;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   modport master (
      output id_op, id_rs, id_rt, id_use_rt,
      output ex_op, ex_rd, ex_wen, ex_taken,
      output dmem_busy,
      input  pc_we, ifid_we, pipe_en,
      input  ifid_flush, idex_bubble,
      input  err, state, stall_cnt
   );

   modport slave (
      input  id_op, id_rs, id_rt, id_use_rt,
      input  ex_op, ex_rd, ex_wen, ex_taken,
      input  dmem_busy,
      output pc_we, ifid_we, pipe_en,
      output ifid_flush, idex_bubble,
      output err, state, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use bubbles, branch flush, memory wait.
// Ports: clk, rstd (async active-low), hz (slave: hazard inputs/enables).
module hazard_ctrl #(
   parameter int unsigned LOAD_LAT = 1,
   parameter logic [7:0]  MAX_WAIT = 8'd200
) (
   input  logic         clk,
   input  logic         rstd,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      LSTALL = 2'd1,
      MWAIT  = 2'd2,
      ERR    = 2'd3
   } state_e;

   localparam logic [2:0] BCNT_INIT = 3'(LOAD_LAT - 1);
   localparam logic [7:0] WAIT_LAST = MAX_WAIT - 8'd1;

   state_e      state_q, state_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        err_q, err_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic xfer;
   logic luh;
   logic pc_we, ifid_we, pipe_en;
   logic ifid_flush, idex_bubble;

   always_comb begin
      xfer = 1'b0;
      if (hz.ex_op inside {6'd32, 6'd33, 6'd34, 6'd35})
         xfer = hz.ex_taken;
      if (hz.ex_op inside {6'd40, 6'd41, 6'd42})
         xfer = 1'b1;
   end

   assign luh = (hz.ex_op == 6'd16) && hz.ex_wen
             && (hz.ex_rd != 5'd0)
             && ((hz.ex_rd == hz.id_rs)
              || (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = state_q;
      bcnt_d      = bcnt_q;
      wcnt_d      = wcnt_q;
      err_d       = err_q;

      if (state_q == ERR) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         pipe_en = 1'b0;
      end else if (hz.dmem_busy) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         pipe_en = 1'b0;
         wcnt_d  = wcnt_q + 8'd1;
         state_d = MWAIT;
         if (wcnt_q == WAIT_LAST) begin
            state_d = ERR;
            err_d   = 1'b1;
         end
      end else begin
         wcnt_d = 8'd0;
         if (xfer) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            bcnt_d      = 3'd0;
            state_d     = RUN;
         end else if (state_q == LSTALL
                   || (state_q == MWAIT && bcnt_q != 3'd0)) begin
            // Still owe bubbles from a load stalled earlier.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            bcnt_d      = bcnt_q - 3'd1;
            state_d     = (bcnt_q == 3'd1) ? RUN : LSTALL;
         end else if (luh) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
            state_d     = RUN;
            if (LOAD_LAT > 1) begin
               bcnt_d  = BCNT_INIT;
               state_d = LSTALL;
            end
         end else begin
            state_d = RUN;
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_we && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_q     <= RUN;
         bcnt_q      <= 3'd0;
         wcnt_q      <= 8'd0;
         err_q       <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         wcnt_q      <= wcnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.pc_we       = pc_we;
   assign hz.ifid_we     = ifid_we;
   assign hz.pipe_en     = pipe_en;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.err         = err_q;
   assign hz.state       = state_q;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule
